// File: rtl/parity_bit.sv
// rtl/parity_bit.sv - 3-input parity generator with registered copy; PARITY_CHECK_EN adds a received-parity checker
// Optional macro: PARITY_CHECK_EN (adds p_in, err, err_cnt).
module parity_bit #(
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
`ifdef PARITY_CHECK_EN
  input  logic                 p_in,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 y,
  output logic                 y_q,
  output logic [2:0]           data_q,
  output logic [1:0]           ones_cnt
);

  localparam logic W_ODD = (ODD_PARITY != 0);

  logic       w_y;
  logic       r_y_q;
  logic [2:0] r_data_q;

  assign w_y      = a ^ b ^ c ^ W_ODD;
  assign y        = w_y;
  assign ones_cnt = {1'b0, a} + {1'b0, b} + {1'b0, c};
  assign y_q      = r_y_q;
  assign data_q   = r_data_q;

  // Reset value is 0 regardless of ODD_PARITY so downstream sees a quiet bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q    <= 1'b0;
      r_data_q <= 3'b000;
    end else begin
      r_y_q    <= w_y;
      r_data_q <= {a, b, c};
    end
  end

`ifdef PARITY_CHECK_EN
  logic                 w_mismatch;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_mismatch = (a ^ b ^ c ^ p_in) != W_ODD;
  assign err        = r_err;
  assign err_cnt    = r_err_cnt;

  // Counter sticks at all-ones rather than wrapping back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_mismatch;
      if (w_mismatch && (r_err_cnt != {ERR_CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_bit.sv
// tb/tb_parity_bit.sv - self-checking bench for parity_bit (even and odd instances)
module tb_parity_bit;

  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  logic       y_e, y_qe, y_o, y_qo;
  logic [2:0] dq_e, dq_o;
  logic [1:0] on_e, on_o;
`ifdef PARITY_CHECK_EN
  logic          p_in = 1'b0;
  logic          err_e, err_o;
  logic [CW-1:0] cnt_e, cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_bit #(.ODD_PARITY(0), .ERR_CNT_W(CW)) u_even (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
`ifdef PARITY_CHECK_EN
    .p_in(p_in), .err(err_e), .err_cnt(cnt_e),
`endif
    .y(y_e), .y_q(y_qe), .data_q(dq_e), .ones_cnt(on_e)
  );

  parity_bit #(.ODD_PARITY(1), .ERR_CNT_W(CW)) u_odd (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
`ifdef PARITY_CHECK_EN
    .p_in(p_in), .err(err_o), .err_cnt(cnt_o),
`endif
    .y(y_o), .y_q(y_qo), .data_q(dq_o), .ones_cnt(on_o)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: remembers what was on the inputs at each capturing edge.
  logic [2:0] m_word    = 3'b000;
  logic       m_cleared = 1'b1;
  int         m_cnt     = 0;
  logic       m_pin     = 1'b0;
  logic       run       = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word    = 3'b000;
      m_cleared = 1'b1;
      m_cnt     = 0;
      m_pin     = 1'b0;
    end else begin
      m_word    = {a, b, c};
      m_cleared = 1'b0;
`ifdef PARITY_CHECK_EN
      m_pin = p_in;
      if ((($countones({a, b, c, p_in}) % 2) != 0) && m_cnt < (2 ** CW) - 1)
        m_cnt = m_cnt + 1;
`endif
    end
  end

  function automatic logic par_of(input logic [2:0] w, input int odd);
    return logic'((($countones(w) + odd) % 2));
  endfunction

  always @(negedge clk) begin
    if (run) begin
      check("y_even",     8'(y_e),  8'(par_of({a, b, c}, 0)));
      check("y_odd",      8'(y_o),  8'(par_of({a, b, c}, 1)));
      check("ones_even",  8'(on_e), 8'($countones({a, b, c})));
      check("ones_odd",   8'(on_o), 8'($countones({a, b, c})));
      check("yq_even",    8'(y_qe), m_cleared ? 8'd0 : 8'(par_of(m_word, 0)));
      check("yq_odd",     8'(y_qo), m_cleared ? 8'd0 : 8'(par_of(m_word, 1)));
      check("dq_even",    8'(dq_e), 8'(m_word));
      check("dq_odd",     8'(dq_o), 8'(m_word));
`ifdef PARITY_CHECK_EN
      check("err_model",  8'(err_e),
            m_cleared ? 8'd0 : 8'(($countones({m_word, m_pin}) % 2) != 0));
      check("cnt_model",  8'(cnt_e), 8'(m_cnt));
`endif
    end
  end

  task automatic to_mid;
    @(negedge clk);
    #1;
  endtask

  logic [7:0] ytab_even = 8'b10010110;
  logic [7:0] ytab_odd  = 8'b01101001;
  logic [1:0] otab [8]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [3:0] vec  [12] = '{4'b0000, 4'b0011, 4'b1010, 4'b1111, 4'b0110, 4'b1001,
                            4'b0101, 4'b1100, 4'b0111, 4'b1000, 4'b0010, 4'b1110};
`ifdef PARITY_CHECK_EN
  logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] w;
    #1;
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      {a, b, c} = w;
      #1;
      check("sweep_y_even", 8'(y_e),  8'(ytab_even[i]));
      check("sweep_y_odd",  8'(y_o),  8'(ytab_odd[i]));
      check("sweep_ones_e", 8'(on_e), 8'(otab[i]));
      check("sweep_ones_o", 8'(on_o), 8'(otab[i]));
    end
    run = 1'b1;

    // Reset held across edges: combinational follows, registers stay cleared.
    to_mid;
    {a, b, c} = 3'b101;
    #1;
    check("rst_y_101", 8'(y_e),  8'd0);
    check("rst_yq",    8'(y_qe), 8'd0);
    check("rst_yq_o",  8'(y_qo), 8'd0);
    check("rst_dq",    8'(dq_e), 8'd0);
    #10;
    {a, b, c} = 3'b111;
    #1;
    check("rst_y_111", 8'(y_e),  8'd1);
    check("rst_yq2",   8'(y_qe), 8'd0);
    check("rst_dq2",   8'(dq_e), 8'd0);
    #9;

    // First capture only after the next edge.
    to_mid;
    rst = 1'b0;
    {a, b, c} = 3'b001;
    #1;
    check("pre_edge_y",  8'(y_e),  8'd1);
    check("pre_edge_yq", 8'(y_qe), 8'd0);
    check("pre_edge_dq", 8'(dq_e), 8'd0);
    @(posedge clk);
    #1;
    check("post_edge_yq", 8'(y_qe), 8'd1);
    check("post_edge_dq", 8'(dq_e), 8'b001);

    // Asynchronous clear between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_yq",   8'(y_qe), 8'd0);
    check("async_dq",   8'(dq_e), 8'd0);
    check("async_y",    8'(y_e),  8'd1);
    check("async_yq_o", 8'(y_qo), 8'd0);
    to_mid;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      to_mid;
      {a, b, c} = vec[i][3:1];
`ifdef PARITY_CHECK_EN
      p_in = vec[i][0];
`endif
    end
    to_mid;

`ifdef PARITY_CHECK_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    {a, b, c} = 3'b011;
    p_in = 1'b0;
    @(posedge clk);
    #1;
    check("chk_err_ok", 8'(err_e), 8'd0);
    check("chk_cnt_ok", 8'(cnt_e), 8'd0);
    to_mid;
    p_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("chk_err_bad", 8'(err_e), 8'd1);
      check("chk_cnt_sat", 8'(cnt_e), 8'(cnt_exp[k]));
    end
    #1;
    rst = 1'b1;
    #1;
    check("chk_rst_err", 8'(err_e), 8'd0);
    check("chk_rst_cnt", 8'(cnt_e), 8'd0);
    to_mid;
    rst = 1'b0;
    to_mid;
`endif

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_bit.md
Name: parity_bit

Overview:
- 3-input even-parity generator. Inputs a, b, c; primary output y.
- y is purely combinational.
- A registered copy of the result and of the input vector is provided for downstream synchronous logic.
- Sits at the leaf of a data-protection path: it generates the parity bit appended to a 3-bit word.

Parameters:
- ODD_PARITY, 0, 0 = even parity (y = a^b^c); 1 = odd parity (y = ~(a^b^c)).
- ERR_CNT_W, 8, width of the error counter. Used only when PARITY_CHECK_EN is defined.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- a  input  1  data bit 2 (MSB of word {a,b,c}).
- b  input  1  data bit 1.
- c  input  1  data bit 0 (LSB).
- y  output  1  combinational parity bit.
- y_q  output  1  registered parity bit.
- data_q  output  3  registered word {a,b,c}.
- ones_cnt  output  2  combinational count of 1s among a, b, c. Value 0..3; y(even) equals ones_cnt[0].

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- y = a ^ b ^ c ^ ODD_PARITY.
  - Zero-latency combinational path.
  - Independent of clk and rst; valid during reset.
  - X/Z on any input may propagate to y; no masking.
- ones_cnt = a + b + c, zero-extended to 2 bits. Combinational; never wraps (max 3).
- y_q and data_q:
  - Update on every rising clk edge to the current y and {a,b,c}.
  - Latency is 1 cycle; no enable and no handshake.
- Reset:
  - rst high clears y_q = 0 and data_q = 3'b000 immediately, without waiting for a clock edge.
  - The reset values hold while rst is high, even when ODD_PARITY = 1.
  - First capture happens on the first rising clk edge after rst deasserts.
- Reset asserted mid-operation: registered outputs clear asynchronously; combinational outputs are unaffected.
- Inputs changing in the same delta as the clk edge: the value present before the edge is captured (standard nonblocking semantics).
- No state machine. There are no full/empty or wrap conditions apart from the error counter below.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined, the following are added:
  - Input p_in (1 bit): the received parity bit.
  - Output err (1 bit, registered): err is set to 1 when (a^b^c^p_in) != ODD_PARITY, else 0. Updates each clk edge; reset value 0.
  - Output err_cnt (ERR_CNT_W bits, registered):
    - Increments by 1 on every edge where the computed mismatch is 1.
    - Saturates at all-ones; it does not wrap.
    - Reset value 0.
- When not defined, p_in, err and err_cnt do not exist.
- All other behaviour is identical with or without the macro.

Test Plan:
- Exhaustive sweep, ODD_PARITY=0, {a,b,c} = 000..111 -> y = 0,1,1,0,1,0,0,1 and ones_cnt = 0,1,1,2,1,2,2,3.
- Hold rst=1 for 20 ns, driving {a,b,c}=101 then 111 -> y follows the inputs (0 then 1) while y_q stays 0 and data_q stays 000.
- Deassert rst, apply 001 before an edge -> y=1 immediately; y_q=1 and data_q=001 after the next rising edge, not before.
- With y_q=1, assert rst between edges -> y_q=0 and data_q=000 within the same timestep, with no clock edge required.
- ODD_PARITY=1 sweep -> y = 1,0,0,1,0,1,1,0 for 000..111; ones_cnt unchanged.
- PARITY_CHECK_EN, ERR_CNT_W=2:
  - {a,b,c}=011, p_in=0 -> err=0 after the edge.
  - p_in=1 for 5 consecutive edges -> err=1 each cycle; err_cnt reads 1, 2, 3, 3, 3 (saturates).
  - rst -> err=0 and err_cnt=0.
